// File: rtl/chacha_block_sequencer.sv
// Gathers AXIS plaintext into keystream-sized blocks, launches the ChaCha core
// with the running block counter, then streams plaintext XOR keystream out.
module chacha_block_sequencer #(
  parameter int BLOCK_WORDS = 16,
  parameter int CTR_WIDTH   = 32
) (
  input  logic                           aclk,
  input  logic                           areset,
  input  logic                           cfg_enable,
  input  logic                           cfg_counter_load,
  input  logic [CTR_WIDTH-1:0]           cfg_counter_init,
  input  logic [31:0]                    s_axis_tdata,
  input  logic                           s_axis_tvalid,
  input  logic                           s_axis_tlast,
  output logic                           s_axis_tready,
  output logic [31:0]                    m_axis_tdata,
  output logic                           m_axis_tvalid,
  output logic                           m_axis_tlast,
  input  logic                           m_axis_tready,
  output logic                           core_start,
  output logic [CTR_WIDTH-1:0]           core_counter,
  input  logic                           core_ready,
  input  logic                           core_done,
  output logic [$clog2(BLOCK_WORDS)-1:0] core_ks_idx,
  input  logic [31:0]                    core_ks_word,
  output logic                           busy,
  output logic [31:0]                    blocks_done,
  output logic                           ctr_wrap
);

  localparam int IW = $clog2(BLOCK_WORDS);

  typedef enum logic [2:0] {S_IDLE, S_FILL, S_START, S_WAIT, S_DRAIN} state_t;

  state_t               r_state;
  state_t               w_state_next;
  logic [31:0]          r_buf [BLOCK_WORDS];
  logic [IW-1:0]        r_wr_idx;
  logic [IW-1:0]        r_rd_idx;
  logic [IW-1:0]        r_last_idx;
  logic                 r_blk_last;
  logic [CTR_WIDTH-1:0] r_counter;
  logic                 r_ctr_wrap;
  logic [31:0]          r_blocks_done;

  logic                 w_in_hs;
  logic                 w_close;
  logic                 w_out_hs;
  logic                 w_final;
  logic                 w_load;
  logic [CTR_WIDTH-1:0] w_ctr_inc;
  logic                 w_wrap_next;

  assign w_in_hs     = (r_state == S_FILL) && s_axis_tvalid;
  assign w_close     = w_in_hs && (s_axis_tlast || (r_wr_idx == IW'(BLOCK_WORDS - 1)));
  assign w_out_hs    = (r_state == S_DRAIN) && m_axis_tready;
  assign w_final     = w_out_hs && (r_rd_idx == r_last_idx);
  assign w_load      = (r_state == S_IDLE) && cfg_counter_load;
  assign w_ctr_inc   = r_counter + 1'b1;
  assign w_wrap_next = r_ctr_wrap | (w_ctr_inc == '0);

  always_ff @(posedge aclk) begin
    if (areset) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next  = r_state;
    s_axis_tready = 1'b0;
    m_axis_tvalid = 1'b0;
    core_start    = 1'b0;
    busy          = (r_state != S_IDLE);
    case (r_state)
      S_IDLE: begin
        // A same-cycle load clears the wrap flag before the start decision.
        if (cfg_enable && !(r_ctr_wrap && !cfg_counter_load)) w_state_next = S_FILL;
      end
      S_FILL: begin
        s_axis_tready = 1'b1;
        if (w_close) w_state_next = S_START;
      end
      S_START: begin
        core_start = core_ready;
        if (core_ready) w_state_next = S_WAIT;
      end
      S_WAIT: begin
        if (core_done) w_state_next = S_DRAIN;
      end
      S_DRAIN: begin
        m_axis_tvalid = 1'b1;
        if (w_final) w_state_next = (cfg_enable && !w_wrap_next) ? S_FILL : S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Plaintext buffer carries no reset; stale words are never read back.
  always_ff @(posedge aclk) begin
    if (w_in_hs) r_buf[r_wr_idx] <= s_axis_tdata;
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      r_wr_idx      <= '0;
      r_rd_idx      <= '0;
      r_last_idx    <= '0;
      r_blk_last    <= 1'b0;
      r_counter     <= '0;
      r_ctr_wrap    <= 1'b0;
      r_blocks_done <= '0;
    end else begin
      if (w_in_hs) begin
        r_wr_idx <= w_close ? '0 : r_wr_idx + 1'b1;
        if (w_close) begin
          r_last_idx <= r_wr_idx;
          r_blk_last <= s_axis_tlast;
        end
      end
      if (r_state == S_WAIT && core_done) r_rd_idx <= '0;
      if (w_out_hs) r_rd_idx <= w_final ? '0 : r_rd_idx + 1'b1;
      if (w_final) begin
        r_counter     <= w_ctr_inc;
        r_ctr_wrap    <= w_wrap_next;
        r_blocks_done <= r_blocks_done + 32'd1;
      end
      if (w_load) begin
        r_counter  <= cfg_counter_init;
        r_ctr_wrap <= 1'b0;
      end
    end
  end

  assign m_axis_tdata = m_axis_tvalid ? (r_buf[r_rd_idx] ^ core_ks_word) : 32'd0;
  assign m_axis_tlast = m_axis_tvalid && r_blk_last && (r_rd_idx == r_last_idx);
  assign core_ks_idx  = r_rd_idx;
  assign core_counter = r_counter;
  assign blocks_done  = r_blocks_done;
  assign ctr_wrap     = r_ctr_wrap;

endmodule

// File: tb/tb_chacha_block_sequencer.sv
// Bench for chacha_block_sequencer: a simple ChaCha core stand-in, a block-level
// model of the expected ciphertext stream, and directed scenarios.
module tb_chacha_block_sequencer;

  localparam int BW = 16;

  logic        aclk = 1'b0;
  logic        areset, cfg_enable, cfg_counter_load;
  logic [31:0] cfg_counter_init;
  logic [31:0] s_axis_tdata, m_axis_tdata, core_counter, core_ks_word, blocks_done;
  logic        s_axis_tvalid, s_axis_tlast, s_axis_tready;
  logic        m_axis_tvalid, m_axis_tlast, m_axis_tready;
  logic        core_start, core_ready, core_done, busy, ctr_wrap;
  logic [3:0]  core_ks_idx;

  chacha_block_sequencer #(.BLOCK_WORDS(BW), .CTR_WIDTH(32)) dut (
    .aclk(aclk), .areset(areset), .cfg_enable(cfg_enable),
    .cfg_counter_load(cfg_counter_load), .cfg_counter_init(cfg_counter_init),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tlast(s_axis_tlast), .s_axis_tready(s_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tlast(m_axis_tlast), .m_axis_tready(m_axis_tready),
    .core_start(core_start), .core_counter(core_counter),
    .core_ready(core_ready), .core_done(core_done),
    .core_ks_idx(core_ks_idx), .core_ks_word(core_ks_word),
    .busy(busy), .blocks_done(blocks_done), .ctr_wrap(ctr_wrap)
  );

  always #5 aclk = ~aclk;

  function automatic logic [31:0] ks(input int i);
    return 32'(i) * 32'h11111111;
  endfunction

  assign core_ks_word = ks(int'(core_ks_idx));

  int total = 0;
  int bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name, input int act, input int exp);
    total++;
    bad++;
    $display("FAIL %s: got %0d want %0d", name, act, exp);
  endtask

  // Stimulus-controlled knobs read by the helper processes
  logic ready_en = 1'b1;
  int   done_delay = 3;
  logic bp_mode = 1'b0;

  // ChaCha core stand-in
  logic st_s, rs_s, cbusy;
  int   ccnt;
  initial begin
    core_ready = 1'b0; core_done = 1'b0; cbusy = 1'b0; ccnt = 0;
    forever begin
      @(negedge aclk);
      st_s = core_start;
      rs_s = areset;
      @(posedge aclk); #1;
      core_done = 1'b0;
      if (rs_s) begin
        cbusy = 1'b0; ccnt = 0;
      end else if (st_s) begin
        cbusy = 1'b1; ccnt = done_delay;
      end else if (cbusy) begin
        ccnt--;
        if (ccnt <= 0) begin core_done = 1'b1; cbusy = 1'b0; end
      end
      core_ready = ready_en && !cbusy;
    end
  end

  initial begin
    m_axis_tready = 1'b1;
    forever begin
      @(posedge aclk); #1;
      m_axis_tready = bp_mode ? ~m_axis_tready : 1'b1;
    end
  end

  // Block-level model and the per-cycle compare process
  typedef struct {
    logic [31:0] d;
    logic        l;
    logic        eob;
    logic [31:0] ctr;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] ctr_q[$];
  logic [31:0] cur_w[$];
  int          model_blocks = 0;
  logic [31:0] model_ctr = 0;
  logic        model_wrap = 1'b0;
  int          out_total = 0;
  logic [31:0] out_log [256];
  logic [31:0] last_start_ctr = 0;
  int          start_count = 0;
  int          stall_count = 0;
  logic        prev_start = 0, prev_stall = 0, prev_last = 0, prev_done = 0, prev_close = 0;
  logic [31:0] prev_data = 0;

  initial begin
    exp_t e;
    forever begin
      @(negedge aclk);
      if (areset) begin
        exp_q.delete(); ctr_q.delete(); cur_w.delete();
        model_blocks = 0; model_ctr = 0; model_wrap = 1'b0;
        prev_start = 0; prev_stall = 0; prev_done = 0; prev_close = 0;
      end else begin
        check("blocks_done", blocks_done, 32'(model_blocks));
        check("ctr_wrap", {31'd0, ctr_wrap}, {31'd0, model_wrap});
        if (!m_axis_tvalid) check("tdata_idle", m_axis_tdata, 32'd0);
        if (prev_done) check("drain_after_done", {31'd0, m_axis_tvalid}, 32'd1);
        if (prev_close && core_ready) check("start_after_close", {31'd0, core_start}, 32'd1);
        if (core_start) begin
          check("start_ready", {31'd0, core_ready}, 32'd1);
          check("start_single", {31'd0, prev_start}, 32'd0);
          if (ctr_q.size() == 0) fail_now("start_unexpected", 1, 0);
          else begin
            check("core_counter", core_counter, ctr_q[0]);
            void'(ctr_q.pop_front());
          end
          last_start_ctr = core_counter;
          start_count++;
        end
        if (m_axis_tvalid) begin
          check("s_tready_in_drain", {31'd0, s_axis_tready}, 32'd0);
          if (prev_stall) begin
            check("stall_data", m_axis_tdata, prev_data);
            check("stall_last", {31'd0, m_axis_tlast}, {31'd0, prev_last});
          end
          if (exp_q.size() == 0) fail_now("unexpected_out", int'(m_axis_tdata), 0);
          else begin
            check("tdata", m_axis_tdata, exp_q[0].d);
            check("tlast", {31'd0, m_axis_tlast}, {31'd0, exp_q[0].l});
            check("drain_counter", core_counter, exp_q[0].ctr);
            if (m_axis_tready) begin
              out_log[out_total % 256] = m_axis_tdata;
              out_total++;
              if (exp_q[0].eob) begin
                model_blocks++;
                if (exp_q[0].ctr == 32'hFFFFFFFF) model_wrap = 1'b1;
              end
              void'(exp_q.pop_front());
            end
          end
        end
        prev_close = 1'b0;
        if (s_axis_tvalid && s_axis_tready) begin
          cur_w.push_back(s_axis_tdata);
          if (s_axis_tlast || cur_w.size() == BW) begin
            for (int i = 0; i < cur_w.size(); i++) begin
              e.d   = cur_w[i] ^ ks(i);
              e.eob = (i == cur_w.size() - 1);
              e.l   = e.eob && s_axis_tlast;
              e.ctr = model_ctr;
              exp_q.push_back(e);
            end
            ctr_q.push_back(model_ctr);
            model_ctr = model_ctr + 32'd1;
            cur_w.delete();
            prev_close = 1'b1;
          end
        end
        if (cfg_counter_load && !busy) begin
          model_ctr = cfg_counter_init;
          model_wrap = 1'b0;
        end
        if (m_axis_tvalid && !m_axis_tready) stall_count++;
        prev_start = core_start;
        prev_done  = core_done;
        prev_stall = m_axis_tvalid && !m_axis_tready;
        prev_data  = m_axis_tdata;
        prev_last  = m_axis_tlast;
      end
    end
  end

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge aclk); #1;
    end
  endtask

  task automatic send_words(input logic [31:0] base, input int n, input logic last_end);
    logic ok;
    for (int w = 0; w < n; w++) begin
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = base + 32'(w);
      s_axis_tlast  = last_end && (w == n - 1);
      ok = 1'b0;
      for (int c = 0; c < 300 && !ok; c++) begin
        @(negedge aclk);
        ok = s_axis_tready;
        @(posedge aclk); #1;
      end
      if (!ok) fail_now("send_timeout", w, n);
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  task automatic wait_blocks(input int n);
    int c;
    c = 0;
    while (model_blocks < n && c < 2000) begin
      @(negedge aclk);
      c++;
    end
    if (model_blocks < n) fail_now("wait_blocks", model_blocks, n);
    @(posedge aclk); #1;
  endtask

  task automatic pulse_load(input logic [31:0] init);
    cfg_counter_init = init;
    cfg_counter_load = 1'b1;
    tick(1);
    cfg_counter_load = 1'b0;
  endtask

  task automatic check_reset_outputs();
    check("rst_s_tready", {31'd0, s_axis_tready}, 32'd0);
    check("rst_m_tvalid", {31'd0, m_axis_tvalid}, 32'd0);
    check("rst_m_tlast", {31'd0, m_axis_tlast}, 32'd0);
    check("rst_m_tdata", m_axis_tdata, 32'd0);
    check("rst_core_start", {31'd0, core_start}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_ctr_wrap", {31'd0, ctr_wrap}, 32'd0);
    check("rst_counter", core_counter, 32'd0);
    check("rst_blocks_done", blocks_done, 32'd0);
    check("rst_ks_idx", {28'd0, core_ks_idx}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int base_out, snap, snap_stall, seen;
    areset = 1'b1; cfg_enable = 1'b0; cfg_counter_load = 1'b0; cfg_counter_init = 32'd0;
    s_axis_tdata = 32'd0; s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
    tick(3);
    areset = 1'b0;
    @(negedge aclk);
    check_reset_outputs();
    @(posedge aclk); #1;

    // Full block, counter 7
    pulse_load(32'h00000007);
    cfg_enable = 1'b1;
    send_words(32'h0, 16, 1'b1);
    wait_blocks(1);
    check("t1_start_ctr", last_start_ctr, 32'h00000007);
    check("t1_word0", out_log[0], 32'h00000000);
    check("t1_word1", out_log[1], 32'h11111110);
    check("t1_word5", out_log[5], 32'h55555550);
    check("t1_word15", out_log[15], 32'hFFFFFFF0);
    check("t1_counter", core_counter, 32'h00000008);
    check("t1_blocks", blocks_done, 32'd1);

    // Partial block of 5 words
    base_out = out_total;
    send_words(32'h100, 5, 1'b1);
    wait_blocks(2);
    tick(20);
    check("t2_out_count", 32'(out_total - base_out), 32'd5);
    check("t2_word0", out_log[base_out], 32'h00000100);
    check("t2_word4", out_log[base_out + 4], 32'h44444540);
    check("t2_start_ctr", last_start_ctr, 32'h00000008);
    check("t2_counter", core_counter, 32'h00000009);

    // Backpressure during drain
    base_out = out_total;
    snap_stall = stall_count;
    bp_mode = 1'b1;
    send_words(32'h200, 16, 1'b1);
    wait_blocks(3);
    bp_mode = 1'b0;
    check("t3_out_count", 32'(out_total - base_out), 32'd16);
    check("t3_stalls_seen", {31'd0, stall_count > snap_stall}, 32'd1);
    check("t3_start_ctr", last_start_ctr, 32'h00000009);

    // Core not ready after fill; enable dropped mid-block
    ready_en = 1'b0;
    tick(2);
    send_words(32'h300, 16, 1'b0);
    cfg_enable = 1'b0;
    snap = start_count;
    tick(10);
    check("t4_held_off", 32'(start_count - snap), 32'd0);
    check("t4_busy_waiting", {31'd0, busy}, 32'd1);
    ready_en = 1'b1;
    wait_blocks(4);
    check("t4_one_start", 32'(start_count - snap), 32'd1);
    check("t4_start_ctr", last_start_ctr, 32'h0000000A);
    check("t4_idle_after", {31'd0, busy}, 32'd0);

    // Counter wrap
    pulse_load(32'hFFFFFFFF);
    cfg_enable = 1'b1;
    send_words(32'h400, 16, 1'b1);
    wait_blocks(5);
    tick(2);
    check("t5_start_ctr", last_start_ctr, 32'hFFFFFFFF);
    check("t5_counter", core_counter, 32'h00000000);
    check("t5_wrap", {31'd0, ctr_wrap}, 32'd1);
    check("t5_idle", {31'd0, busy}, 32'd0);
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = 32'h500;
    seen = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge aclk);
      if (s_axis_tready) seen++;
      @(posedge aclk); #1;
    end
    s_axis_tvalid = 1'b0;
    check("t5_block2_refused", 32'(seen), 32'd0);
    pulse_load(32'h00000000);
    send_words(32'h500, 16, 1'b1);
    wait_blocks(6);
    check("t5_b2_start_ctr", last_start_ctr, 32'h00000000);
    check("t5_b2_wrap", {31'd0, ctr_wrap}, 32'd0);
    check("t5_b2_counter", core_counter, 32'h00000001);

    // Reset while waiting on the core
    done_delay = 40;
    snap = start_count;
    send_words(32'h600, 16, 1'b1);
    seen = 0;
    for (int c = 0; c < 50 && start_count == snap; c++) tick(1);
    if (start_count == snap) fail_now("t6_start_timeout", start_count, snap + 1);
    tick(3);
    check("t6_in_wait", {31'd0, busy}, 32'd1);
    areset = 1'b1;
    tick(1);
    areset = 1'b0;
    @(negedge aclk);
    check_reset_outputs();
    @(posedge aclk); #1;
    done_delay = 3;
    send_words(32'h700, 16, 1'b1);
    wait_blocks(1);
    check("t6_start_ctr", last_start_ctr, 32'h00000000);
    check("t6_counter", core_counter, 32'h00000001);
    check("t6_blocks", blocks_done, 32'd1);

    tick(5);
    check("end_exp_empty", 32'(exp_q.size()), 32'd0);
    check("end_ctr_empty", 32'(ctr_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
